pipe_ctrl_unit: RTL and testbench

Parametrised decode-stage control unit for the pipelined RISC-V core. It decodes the IF/ID instruction into the full control bundle and registers it into the ID/EX stage. It detects load-use hazards and inserts a configurable number of bubbles to cover multi-cycle data memory. It flushes on taken branches and latches a sticky illegal-opcode flag.

---
 rtl/pipe_ctrl_unit.sv | 183 ++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit
// Decode-stage control unit for the pipelined RISC-V core. It decodes the
// IF/ID instruction into the control bundle, registers it into ID/EX,
// stalls MEM_LAT cycles on a load-use hazard, flushes on a taken branch and
// keeps a sticky illegal-opcode flag.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   if_id_valid/instr   instruction presented by the IF/ID register
//   branch_taken_ex     EX resolved a taken branch/jump this cycle
//   pc_write            PC update enable (combinational)
//   if_id_write         IF/ID load enable (combinational)
//   if_id_flush         clear IF/ID (combinational, = branch_taken_ex)
//   id_ex_*             registered control bundle and destination index
//   illegal             sticky flag, set by a valid undefined opcode
module pipe_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 2,
    parameter int MEM_LAT    = 1,
    parameter bit EN_JAL     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_id_valid,
    input  logic [31:0]           if_id_instr,
    input  logic                  branch_taken_ex,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_valid,
    output logic                  id_ex_alusrc,
    output logic                  id_ex_memtoreg,
    output logic                  id_ex_memread,
    output logic                  id_ex_memwrite,
    output logic                  id_ex_branch,
    output logic                  id_ex_jump,
    output logic                  id_ex_regwrite,
    output logic [ALUOP_W-1:0]    id_ex_aluop,
    output logic [REG_ADDR_W-1:0] id_ex_rd,
    output logic                  illegal
);

    localparam int CNT_W = $clog2(MEM_LAT) + 1;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // ctrl vector order: alusrc, memtoreg, memread, memwrite, branch, jump, regwrite
    logic [6:0]            ctrl_q;
    logic [ALUOP_W-1:0]    aluop_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  valid_q;
    logic                  illegal_q;

    logic [6:0]            opcode;
    logic [REG_ADDR_W-1:0] rd_f, rs1_f, rs2_f;
    logic [6:0]            dec_ctrl;
    logic [1:0]            dec_aluop;
    logic                  use_rs1, use_rs2, dec_undef;
    logic                  hazard;
    logic                  pc_en;
    logic                  issue;

    // Fields the decoder never looks at.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{if_id_instr[31:25], if_id_instr[14:12]};

    assign opcode = if_id_instr[6:0];
    assign rd_f   = if_id_instr[7  +: REG_ADDR_W];
    assign rs1_f  = if_id_instr[15 +: REG_ADDR_W];
    assign rs2_f  = if_id_instr[20 +: REG_ADDR_W];

    always_comb begin
        dec_ctrl  = 7'b0000000;
        dec_aluop = 2'b00;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        dec_undef = 1'b0;
        case (opcode)
            7'b0110011: begin dec_ctrl = 7'b0000001; dec_aluop = 2'b10; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            7'b0000011: begin dec_ctrl = 7'b1110001; use_rs1 = 1'b1; end
            7'b0100011: begin dec_ctrl = 7'b1001000; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            7'b1100011: begin dec_ctrl = 7'b0000100; dec_aluop = 2'b01; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            7'b0010011: begin dec_ctrl = 7'b1000001; use_rs1 = 1'b1; end
            7'b1101111: begin
                if (EN_JAL) dec_ctrl  = 7'b0000011;
                else        dec_undef = 1'b1;
            end
            7'b0000000: ;
            default:    dec_undef = 1'b1;
        endcase
    end

    // Load in EX whose destination is read by the instruction in ID.
    assign hazard = valid_q & ctrl_q[4] & (rd_q != '0) & if_id_valid &
                    ((use_rs1 & (rs1_f == rd_q)) | (use_rs2 & (rs2_f == rd_q)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_en   = 1'b0;
        issue   = 1'b0;
        if (branch_taken_ex) begin
            // Flush wins over everything, including an ongoing stall.
            state_d = RUN;
            cnt_d   = '0;
            pc_en   = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard) begin
                        // The hazard cycle is itself the first bubble.
                        if (MEM_LAT > 1) begin
                            state_d = STALL;
                            cnt_d   = CNT_W'(MEM_LAT - 1);
                        end
                    end else begin
                        pc_en = 1'b1;
                        issue = if_id_valid;
                    end
                end
                STALL: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            aluop_q   <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_q | (if_id_valid & dec_undef & ~branch_taken_ex);
            if (issue) begin
                valid_q <= 1'b1;
                ctrl_q  <= dec_ctrl;
                aluop_q <= ALUOP_W'(dec_aluop);
                rd_q    <= rd_f;
            end else begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
                aluop_q <= '0;
                rd_q    <= '0;
            end
        end
    end

    // Enables are held low for as long as reset is asserted.
    assign pc_write    = pc_en & rst_n;
    assign if_id_write = pc_en & rst_n;
    assign if_id_flush = branch_taken_ex;

    assign id_ex_valid    = valid_q;
    assign id_ex_alusrc   = ctrl_q[6];
    assign id_ex_memtoreg = ctrl_q[5];
    assign id_ex_memread  = ctrl_q[4];
    assign id_ex_memwrite = ctrl_q[3];
    assign id_ex_branch   = ctrl_q[2];
    assign id_ex_jump     = ctrl_q[1];
    assign id_ex_regwrite = ctrl_q[0];
    assign id_ex_aluop    = aluop_q;
    assign id_ex_rd       = rd_q;
    assign illegal        = illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Testbench for pipe_ctrl_unit: three instances (MEM_LAT 1/3/2, JAL disabled
// on the last) share one stimulus stream and are compared every cycle
// against a behavioural model built from the decode table and stall rules.
module tb_pipe_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_id_valid = 1'b0;
    logic [31:0] if_id_instr = 32'h0;
    logic        branch_taken_ex = 1'b0;

    logic [2:0]       pcw_w, ifw_w, flush_w, ill_w;
    logic [2:0][14:0] idex_w;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state per instance: {valid, 7 ctrl bits, aluop[1:0], rd[4:0]}
    logic [14:0] m_idex [3];
    int          m_stall [3];
    bit          m_ill [3];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        logic v_o, as_o, mt_o, mr_o, mw_o, b_o, j_o, rw_o;
        logic [1:0] aop_o;
        logic [4:0] rd_o;
        pipe_ctrl_unit #(
            .REG_ADDR_W(5),
            .ALUOP_W   (2),
            .MEM_LAT   (gi == 1 ? 3 : (gi == 2 ? 2 : 1)),
            .EN_JAL    (gi == 2 ? 1'b0 : 1'b1)
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .if_id_valid    (if_id_valid),
            .if_id_instr    (if_id_instr),
            .branch_taken_ex(branch_taken_ex),
            .pc_write       (pcw_w[gi]),
            .if_id_write    (ifw_w[gi]),
            .if_id_flush    (flush_w[gi]),
            .id_ex_valid    (v_o),
            .id_ex_alusrc   (as_o),
            .id_ex_memtoreg (mt_o),
            .id_ex_memread  (mr_o),
            .id_ex_memwrite (mw_o),
            .id_ex_branch   (b_o),
            .id_ex_jump     (j_o),
            .id_ex_regwrite (rw_o),
            .id_ex_aluop    (aop_o),
            .id_ex_rd       (rd_o),
            .illegal        (ill_w[gi])
        );
        assign idex_w[gi] = {v_o, as_o, mt_o, mr_o, mw_o, b_o, j_o, rw_o, aop_o, rd_o};
    end

    function automatic int lat_of(input int i);
        return (i == 1) ? 3 : ((i == 2) ? 2 : 1);
    endfunction

    function automatic bit jal_of(input int i);
        return (i != 2);
    endfunction

    // {undefined, uses rs1, uses rs2, alusrc..regwrite, aluop}
    function automatic logic [11:0] dec(input logic [6:0] op, input bit en_jal);
        case (op)
            7'b0110011: return 12'b011_0000001_10;
            7'b0000011: return 12'b010_1110001_00;
            7'b0100011: return 12'b011_1001000_00;
            7'b1100011: return 12'b011_0000100_01;
            7'b0010011: return 12'b010_1000001_00;
            7'b1101111: return en_jal ? 12'b000_0000011_00 : 12'b100_0000000_00;
            7'b0000000: return 12'b0;
            default:    return 12'b100_0000000_00;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %h exp %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_idex[i]  = '0;
            m_stall[i] = 0;
            m_ill[i]   = 1'b0;
        end
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_idex%0d", tag, i), 32'(idex_w[i]), 32'h0);
            chk($sformatf("%s_ill%0d", tag, i), 32'(ill_w[i]), 32'h0);
            chk($sformatf("%s_pcw%0d", tag, i), 32'(pcw_w[i]), 32'h0);
            chk($sformatf("%s_ifw%0d", tag, i), 32'(ifw_w[i]), 32'h0);
            chk($sformatf("%s_flush%0d", tag, i), 32'(flush_w[i]), 32'(branch_taken_ex));
        end
    endtask

    // One clock: drive, check combinational and registered outputs against
    // the model, then advance the model across the rising edge.
    task automatic step(input bit v, input logic [31:0] ins, input bit br);
        logic [11:0] d;
        logic [4:0]  mrd;
        bit          hz, pcw;
        logic [14:0] nx [3];
        int          ns [3];
        bit          ni [3];
        if_id_valid     = v;
        if_id_instr     = ins;
        branch_taken_ex = br;
        #1;
        $display("cyc %0d v=%0b instr=%08h br=%0b pcw=%b idex0=%h idex1=%h idex2=%h ill=%b",
                 cyc, v, ins, br, pcw_w, idex_w[0], idex_w[1], idex_w[2], ill_w);
        for (int i = 0; i < 3; i++) begin
            d   = dec(ins[6:0], jal_of(i));
            mrd = m_idex[i][4:0];
            hz  = m_idex[i][14] && m_idex[i][11] && (mrd != 0) && v &&
                  ((d[10] && ins[19:15] == mrd) || (d[9] && ins[24:20] == mrd));
            if (br) begin
                pcw = 1'b1; nx[i] = '0; ns[i] = 0;
            end else if (m_stall[i] > 0) begin
                pcw = 1'b0; nx[i] = '0; ns[i] = m_stall[i] - 1;
            end else if (hz) begin
                pcw = 1'b0; nx[i] = '0; ns[i] = lat_of(i) - 1;
            end else begin
                pcw = 1'b1; nx[i] = v ? {1'b1, d[8:0], ins[11:7]} : 15'h0; ns[i] = 0;
            end
            ni[i] = m_ill[i] | (v & d[11] & ~br);
            chk($sformatf("pcw%0d", i), 32'(pcw_w[i]), 32'(pcw));
            chk($sformatf("ifw%0d", i), 32'(ifw_w[i]), 32'(pcw));
            chk($sformatf("flush%0d", i), 32'(flush_w[i]), 32'(br));
            chk($sformatf("idex%0d", i), 32'(idex_w[i]), 32'(m_idex[i]));
            chk($sformatf("ill%0d", i), 32'(ill_w[i]), 32'(m_ill[i]));
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            m_idex[i]  = nx[i];
            m_stall[i] = ns[i];
            m_ill[i]   = ni[i];
        end
        cyc++;
        @(negedge clk);
    endtask

    // Reset dropped and released between clock edges.
    task automatic async_reset(input logic [31:0] ins);
        if_id_valid = 1'b1;
        if_id_instr = ins;
        #2 rst_n = 1'b0;
        #1;
        $display("cyc %0d async reset asserted", cyc);
        check_reset("arst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1 check_reset("arst_hold");
        #1 rst_n = 1'b1;
        cyc++;
    endtask

    localparam logic [31:0] ADDI  = 32'h00010093; // addi x1,x2
    logic [31:0] lw5, add65, lw0, add60, sw5, rand_ins;
    logic [6:0]  ops [9];

    initial begin
        model_reset();
        lw5   = mk(7'h03, 5'd5, 5'd1, 5'd0);
        add65 = mk(7'h33, 5'd6, 5'd5, 5'd7);
        lw0   = mk(7'h03, 5'd0, 5'd1, 5'd0);
        add60 = mk(7'h33, 5'd6, 5'd0, 5'd7);
        sw5   = mk(7'h23, 5'd0, 5'd1, 5'd5);
        ops   = '{7'h33, 7'h03, 7'h23, 7'h63, 7'h13, 7'h6F, 7'h00, 7'h7F, 7'h0B};

        @(negedge clk);
        check_reset("rst");
        #1 rst_n = 1'b1;

        // Legal stream
        step(1, ADDI, 0);
        step(1, mk(7'h33, 5'd3, 5'd1, 5'd2), 0);
        step(1, mk(7'h23, 5'd0, 5'd3, 5'd4), 0);
        step(1, mk(7'h63, 5'd6, 5'd1, 5'd2), 0);
        step(1, mk(7'h6F, 5'd1, 5'd0, 5'd0), 0);
        step(1, 32'h0, 0);
        step(1, 32'h0, 0);

        // Load-use via rs1, ADD held in IF/ID while stalled
        step(1, lw5, 0);
        repeat (4) step(1, add65, 0);
        step(1, 32'h0, 0);
        step(1, 32'h0, 0);

        // Load to x0 never stalls
        step(1, lw0, 0);
        step(1, add60, 0);
        step(1, 32'h0, 0);

        // Load-use via rs2
        step(1, lw5, 0);
        repeat (4) step(1, sw5, 0);
        step(1, 32'h0, 0);
        step(1, 32'h0, 0);

        // Flush during the second stall cycle
        step(1, lw5, 0);
        step(1, add65, 0);
        step(1, add65, 1);
        step(1, 32'h0, 0);
        step(1, add65, 0);
        step(1, 32'h0, 0);

        // Asynchronous reset in the middle of a stall
        step(1, lw5, 0);
        step(1, add65, 0);
        async_reset(add65);
        step(1, add65, 0);
        step(1, 32'h0, 0);

        // Undefined opcode: invalid slot first, then valid
        step(0, 32'h0000007F, 0);
        step(1, 32'h0000007F, 1);
        step(1, 32'h0000037F, 0);
        step(0, 32'h0, 0);
        step(1, 32'h0, 0);

        // Randomized traffic with small register indices to provoke hazards
        for (int n = 0; n < 300; n++) begin
            rand_ins = $urandom;
            rand_ins[6:0]   = ops[$urandom_range(0, 8)];
            rand_ins[11:7]  = 5'($urandom_range(0, 3));
            rand_ins[19:15] = 5'($urandom_range(0, 3));
            rand_ins[24:20] = 5'($urandom_range(0, 3));
            step($urandom_range(0, 7) != 0, rand_ins, $urandom_range(0, 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
